// File: rtl/multi_channel_memory_controller.sv
// Round-robin arbiter of NUM_CHANNELS request channels onto one single-port synchronous BRAM.
// Optional byte-lane write strobes: define MULTI_CHANNEL_MEMORY_CONTROLLER_WRITE_STROBE_EN.
//
// state   | meaning
// IDLE    | searching for the next valid channel; the grant is accepted in the same cycle
// RESPOND | response of the granted channel held until that channel accepts it
module multi_channel_memory_controller #(
    parameter int NUM_CHANNELS   = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int CAPACITY_WORDS = 1024
) (
    input  logic                                  clock,
    input  logic                                  clear_n,
    input  logic [NUM_CHANNELS-1:0]               ch_to_controller_valid,
    output logic [NUM_CHANNELS-1:0]               ch_to_controller_ready,
    input  logic [NUM_CHANNELS-1:0]               ch_to_controller_write,
    input  logic [NUM_CHANNELS*ADDRESS_WIDTH-1:0] ch_to_controller_address,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]    ch_to_controller_write_data,
`ifdef MULTI_CHANNEL_MEMORY_CONTROLLER_WRITE_STROBE_EN
    input  logic [NUM_CHANNELS*(DATA_WIDTH/8)-1:0] ch_to_controller_write_strobe,
`endif
    output logic [NUM_CHANNELS-1:0]               controller_to_ch_valid,
    input  logic [NUM_CHANNELS-1:0]               controller_to_ch_ready,
    output logic                                  controller_to_ch_error,
    output logic [DATA_WIDTH-1:0]                 controller_to_ch_read_data
);
    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(BYTES);
    localparam int PTR_W      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int MEM_AW     = (CAPACITY_WORDS > 1) ? $clog2(CAPACITY_WORDS) : 1;

    typedef enum logic {IDLE, RESPOND} state_t;

    state_t                   state, state_next;
    logic [PTR_W-1:0]         rr_ptr, grant_idx, granted;
    logic                     grant_found, grant_write, grant_error, accept;
    logic                     misaligned, out_of_range;
    int                       cand;
    logic [ADDRESS_WIDTH-1:0] grant_addr, word_index;
    logic [DATA_WIDTH-1:0]    grant_wdata;
    logic [MEM_AW-1:0]        mem_idx;
    logic [DATA_WIDTH-1:0]    mem [CAPACITY_WORDS];
`ifdef MULTI_CHANNEL_MEMORY_CONTROLLER_WRITE_STROBE_EN
    logic [BYTES-1:0]         grant_strobe;
`endif

    // First valid channel strictly after the last winner, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 1; i <= NUM_CHANNELS; i++) begin
            cand = (int'(rr_ptr) + i) % NUM_CHANNELS;
            if (!grant_found && ch_to_controller_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(cand);
            end
        end
    end

    always_comb begin
        grant_addr  = ch_to_controller_address[grant_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        grant_wdata = ch_to_controller_write_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        grant_write = ch_to_controller_write[grant_idx];
        word_index  = grant_addr >> BYTE_SHIFT;
        misaligned  = |(grant_addr & ADDRESS_WIDTH'(BYTES - 1));
        // Full-width compare so that high address bits cannot alias into the array.
        out_of_range = {1'b0, word_index} >= (ADDRESS_WIDTH + 1)'(CAPACITY_WORDS);
        grant_error  = misaligned | out_of_range;
        mem_idx      = word_index[MEM_AW-1:0];
    end

`ifdef MULTI_CHANNEL_MEMORY_CONTROLLER_WRITE_STROBE_EN
    assign grant_strobe = ch_to_controller_write_strobe[grant_idx*BYTES +: BYTES];
`endif

    assign accept = (state == IDLE) && grant_found && clear_n;

    always_comb begin
        state_next             = state;
        ch_to_controller_ready = '0;
        controller_to_ch_valid = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    ch_to_controller_ready[grant_idx] = 1'b1;
                    state_next                        = RESPOND;
                end
            end
            RESPOND: begin
                controller_to_ch_valid[granted] = 1'b1;
                if (controller_to_ch_ready[granted]) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state                      <= IDLE;
            rr_ptr                     <= PTR_W'(NUM_CHANNELS - 1);
            granted                    <= '0;
            controller_to_ch_error     <= 1'b0;
            controller_to_ch_read_data <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                rr_ptr                 <= grant_idx;
                granted                <= grant_idx;
                controller_to_ch_error <= grant_error;
                if (grant_error || grant_write) controller_to_ch_read_data <= '0;
                else                            controller_to_ch_read_data <= mem[mem_idx];
            end
        end
    end

    // Array has no reset so it maps onto block RAM and survives clear_n.
    always_ff @(posedge clock) begin
        if (accept && !grant_error && grant_write) begin
`ifdef MULTI_CHANNEL_MEMORY_CONTROLLER_WRITE_STROBE_EN
            for (int b = 0; b < BYTES; b++) begin
                if (grant_strobe[b]) mem[mem_idx][b*8 +: 8] <= grant_wdata[b*8 +: 8];
            end
`else
            mem[mem_idx] <= grant_wdata;
`endif
        end
    end
endmodule

// File: tb/tb_multi_channel_memory_controller.sv
// Directed bench for multi_channel_memory_controller (3 channels, 32-bit words, 1024 words).
module tb_multi_channel_memory_controller;
    logic        clock = 1'b0;
    logic        clear_n;
    logic [2:0]  req_valid, req_ready, req_write, rsp_valid, rsp_ready;
    logic [95:0] req_address, req_wdata;
    logic        rsp_error;
    logic [31:0] rsp_rdata;
`ifdef MULTI_CHANNEL_MEMORY_CONTROLLER_WRITE_STROBE_EN
    logic [11:0] req_strobe;
`endif
    int total = 0;
    int bad   = 0;

    multi_channel_memory_controller dut (
        .clock                       (clock),
        .clear_n                     (clear_n),
        .ch_to_controller_valid      (req_valid),
        .ch_to_controller_ready      (req_ready),
        .ch_to_controller_write      (req_write),
        .ch_to_controller_address    (req_address),
        .ch_to_controller_write_data (req_wdata),
`ifdef MULTI_CHANNEL_MEMORY_CONTROLLER_WRITE_STROBE_EN
        .ch_to_controller_write_strobe (req_strobe),
`endif
        .controller_to_ch_valid      (rsp_valid),
        .controller_to_ch_ready      (rsp_ready),
        .controller_to_ch_error      (rsp_error),
        .controller_to_ch_read_data  (rsp_rdata)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        clear_n = 1'b0;
        step();
        step();
        clear_n = 1'b1;
    endtask

    task automatic transact(input int ch, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic exp_err,
                            input logic [31:0] exp_rd, input string tag);
        int waited = 0;
        logic [2:0] onehot = 3'b001 << ch;
        req_valid[ch]          = 1'b1;
        req_write[ch]          = wr;
        req_address[ch*32+:32] = addr;
        req_wdata[ch*32+:32]   = data;
        #1;
        while (!req_ready[ch] && waited < 20) begin
            step();
            waited++;
        end
        check({tag, " ready"}, {29'd0, req_ready}, {29'd0, onehot});
        step();
        req_valid[ch] = 1'b0;
        check({tag, " rsp_valid"}, {29'd0, rsp_valid}, {29'd0, onehot});
        check({tag, " error"}, {31'd0, rsp_error}, {31'd0, exp_err});
        check({tag, " rdata"}, rsp_rdata, exp_rd);
        rsp_ready[ch] = 1'b1;
        step();
        rsp_ready[ch] = 1'b0;
        check({tag, " rsp_done"}, {29'd0, rsp_valid}, 32'd0);
    endtask

    function automatic logic [1:0] enc(input logic [2:0] oh);
        return oh[1] ? 2'd1 : (oh[2] ? 2'd2 : 2'd0);
    endfunction

    // Collect n grants with zero-stall responders; consecutive grants must be 2 cycles apart.
    task automatic rr_run(input logic [2:0] mask, input int n, input logic [11:0] exp_seq,
                          input string tag);
        int got = 0, last = -1, cyc = 0;
        do_reset();
        req_write   = 3'b000;
        req_address = {32'h10, 32'h10, 32'h10};
        rsp_ready   = 3'b111;
        req_valid   = mask;
        #1;
        while (got < n && cyc < 40) begin
            if (req_ready != 3'b000) begin
                check($sformatf("%s order%0d", tag, got), {30'd0, enc(req_ready)},
                      {30'd0, exp_seq[got*2+:2]});
                if (last >= 0) check($sformatf("%s gap%0d", tag, got), cyc - last, 32'd2);
                last = cyc;
                got++;
            end
            step();
            cyc++;
        end
        if (got < n) check({tag, " timeout"}, got, n);
        req_valid = 3'b000;
        step();
        rsp_ready = 3'b000;
        step();
    endtask

    initial begin
        clear_n     = 1'b1;
        req_valid   = '0;
        req_write   = '0;
        req_address = '0;
        req_wdata   = '0;
        rsp_ready   = '0;
`ifdef MULTI_CHANNEL_MEMORY_CONTROLLER_WRITE_STROBE_EN
        req_strobe  = '1;
`endif
        do_reset();
        check("reset ready", {29'd0, req_ready}, 32'd0);
        check("reset rsp_valid", {29'd0, rsp_valid}, 32'd0);
        check("reset error", {31'd0, rsp_error}, 32'd0);
        check("reset rdata", rsp_rdata, 32'd0);

        transact(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, "wr10");
        transact(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, "rd10");

        transact(0, 1'b0, 32'h6, 32'h0, 1'b1, 32'h0, "rd_mis");
        transact(0, 1'b1, 32'h12, 32'h12345678, 1'b1, 32'h0, "wr_mis");
        transact(0, 1'b1, 32'h1000, 32'h55555555, 1'b1, 32'h0, "wr_oor");
        transact(0, 1'b1, 32'h80000010, 32'h11111111, 1'b1, 32'h0, "wr_alias");
        transact(0, 1'b1, 32'hFFC, 32'hCAFEF00D, 1'b0, 32'h0, "wr_last");
        transact(0, 1'b0, 32'hFFC, 32'h0, 1'b0, 32'hCAFEF00D, "rd_last");
        transact(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, "rd_unchanged");

        rr_run(3'b111, 6, {2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0}, "rr_all");
        rr_run(3'b101, 4, {4'd0, 2'd2, 2'd0, 2'd2, 2'd0}, "rr_skip");

        // Backpressure: pointer at 0 so ch1 wins over ch0.
        do_reset();
        transact(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, "bp_pre");
        req_write   = 3'b000;
        req_address = {32'h0, 32'h10, 32'hFFC};
        req_valid   = 3'b011;
        #1;
        check("bp grant1", {29'd0, req_ready}, 32'b010);
        step();
        req_valid[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp valid%0d", i), {29'd0, rsp_valid}, 32'b010);
            check($sformatf("bp error%0d", i), {31'd0, rsp_error}, 32'd0);
            check($sformatf("bp rdata%0d", i), rsp_rdata, 32'hDEADBEEF);
            check($sformatf("bp noready%0d", i), {29'd0, req_ready}, 32'd0);
            step();
        end
        rsp_ready[1] = 1'b1;
        step();
        rsp_ready[1] = 1'b0;
        check("bp released", {29'd0, rsp_valid}, 32'd0);
        check("bp grant0", {29'd0, req_ready}, 32'b001);
        step();
        req_valid[0] = 1'b0;
        check("bp ch0 valid", {29'd0, rsp_valid}, 32'b001);
        check("bp ch0 rdata", rsp_rdata, 32'hCAFEF00D);
        rsp_ready[0] = 1'b1;
        step();
        rsp_ready[0] = 1'b0;

        // Reset while a write response is pending.
        do_reset();
        req_write[2]        = 1'b1;
        req_address[95:64]  = 32'h20;
        req_wdata[95:64]    = 32'hA5A5A5A5;
        req_valid[2]        = 1'b1;
        #1;
        check("mr grant2", {29'd0, req_ready}, 32'b100);
        step();
        check("mr pending", {29'd0, rsp_valid}, 32'b100);
        clear_n     = 1'b0;
        req_write   = 3'b000;
        req_address = {32'h20, 32'h0, 32'h10};
        req_valid   = 3'b101;
        step();
        check("mr rsp_valid", {29'd0, rsp_valid}, 32'd0);
        check("mr ready", {29'd0, req_ready}, 32'd0);
        check("mr error", {31'd0, rsp_error}, 32'd0);
        check("mr rdata", rsp_rdata, 32'd0);
        clear_n = 1'b1;
        #1;
        check("mr first grant", {29'd0, req_ready}, 32'b001);
        req_valid = 3'b000;
        transact(2, 1'b0, 32'h20, 32'h0, 1'b0, 32'hA5A5A5A5, "mr_rd20");

`ifdef MULTI_CHANNEL_MEMORY_CONTROLLER_WRITE_STROBE_EN
        transact(0, 1'b1, 32'h30, 32'hFFFFFFFF, 1'b0, 32'h0, "sb_full");
        req_strobe[3:0] = 4'b0101;
        transact(0, 1'b1, 32'h30, 32'h00000000, 1'b0, 32'h0, "sb_part");
        req_strobe[3:0] = 4'b0000;
        transact(0, 1'b1, 32'h30, 32'h12345678, 1'b0, 32'h0, "sb_none");
        req_strobe[3:0] = 4'b0000;
        transact(0, 1'b0, 32'h30, 32'h0, 1'b0, 32'hFF00FF00, "sb_rd");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multi_channel_memory_controller.md
Name: multi_channel_memory_controller

Overview:
- Parametrised successor of the fixed three-channel BRAM controller.
- Arbitrates N request channels onto one single-port synchronous BRAM using work-conserving round-robin, which skips idle channels.
- Adds response backpressure: each response is held until the requester accepts it.
- Flags misaligned or out-of-range accesses as errors; errored requests never touch memory.
- Sits between CPU/DMA memory channels and main memory.

Parameters:
- NUM_CHANNELS, 3, number of requesting channels (1..8).
- DATA_WIDTH, 32, word width in bits (multiple of 8, power of two).
- ADDRESS_WIDTH, 32, byte-address width per channel.
- CAPACITY_WORDS, 1024, BRAM depth in words (power of two).

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- clear_n  in  1  reset; synchronous, active-low.
- ch_to_controller_valid  in  NUM_CHANNELS  per-channel request valid.
- ch_to_controller_ready  out  NUM_CHANNELS  per-channel request accept; one-hot or zero.
- ch_to_controller_write  in  NUM_CHANNELS  1 = write, 0 = read.
- ch_to_controller_address  in  NUM_CHANNELS*ADDRESS_WIDTH  byte addresses; channel k occupies slice k.
- ch_to_controller_write_data  in  NUM_CHANNELS*DATA_WIDTH  write data, sliced per channel.
- controller_to_ch_valid  out  NUM_CHANNELS  response valid; one-hot or zero.
- controller_to_ch_ready  in  NUM_CHANNELS  response accept.
- controller_to_ch_error  out  1  error flag of the current response.
- controller_to_ch_read_data  out  DATA_WIDTH  read data of the current response.

Behaviour:
- Reset (clear_n low at a clock edge), takes priority over everything:
  - state = IDLE; all valid/ready outputs 0; error 0; read_data 0.
  - Round-robin pointer = NUM_CHANNELS-1, so channel 0 has priority first.
  - Memory contents are not cleared.
  - Reset during RESPOND discards the pending response; an in-flight write that completed before reset is retained.
- States: IDLE, RESPOND.
- IDLE:
  - grant = first k with valid[k]=1, searching from pointer+1 upward, wrapping modulo NUM_CHANNELS.
  - ready[grant]=1 combinationally; all other ready bits 0. No valid bits set → no ready.
  - Requesters must not make valid depend on ready.
  - On valid&ready: pointer <= grant; latch grant and error; go to RESPOND.
- Error check (evaluated on the granted request):
  - Error if address[log2(DATA_WIDTH/8)-1:0] != 0.
  - Error if word index (address >> log2(DATA_WIDTH/8)) >= CAPACITY_WORDS. Comparison is on the full-width index, so high address bits must not alias.
- Memory access in the accept cycle:
  - Legal write: mem[index] <= write_data.
  - Legal read: read_data register <= mem[index] (synchronous read).
  - Error: no memory access; read_data <= 0.
  - Legal write: read_data <= 0.
- RESPOND:
  - controller_to_ch_valid[granted]=1; error and read_data held stable.
  - Stays in RESPOND until controller_to_ch_ready[granted]=1, then returns to IDLE. ready bits are ignored for non-granted channels.
  - No requests are accepted during RESPOND; all ch_to_controller_ready bits are 0.
- Latency and throughput:
  - Response valid 1 cycle after accept.
  - Peak throughput is 1 request per 2 cycles with zero-stall responders.
  - Back-to-back from one channel: if the response is accepted at cycle t, the next accept can be at t+1.
- Fairness: with all channels continuously valid, grants cycle 0,1,…,N-1,0 with no channel skipped or starved.
- Simultaneous events:
  - A channel deasserting valid in IDLE is simply not granted.
  - Request fields are sampled only in the accept cycle; later changes have no effect on the in-flight transaction.

Optional Feature:
- Macro: MULTI_CHANNEL_MEMORY_CONTROLLER_WRITE_STROBE_EN.
- Defined:
  - Adds port ch_to_controller_write_strobe, in, NUM_CHANNELS*(DATA_WIDTH/8), one bit per byte lane.
  - Legal writes update only bytes whose strobe bit is 1.
  - An all-zero strobe is a legal no-op write and still produces a response.
  - Reads ignore strobes.
- Undefined: port absent; writes update the full word.

Test Plan:
- Reset then single write + read: ch0 writes 0xDEADBEEF to address 0x10; response valid at the cycle after accept, error=0. ch0 then reads 0x10 → read_data=0xDEADBEEF, error=0.
- Error cases:
  - Misaligned read of address 0x6 → error=1, read_data=0, memory unchanged.
  - Address 0x1000 (index 1024, first out of range) → error=1.
  - Address 0xFFC (index 1023) → error=0.
- Round-robin: ch0, ch1 and ch2 held valid continuously → accept order 0,1,2,0,1,2. With only ch0 and ch2 valid → order 0,2,0,2, with ch1 skipped and no idle cycles.
- Backpressure: ch1 read with controller_to_ch_ready[1] low for 5 cycles → valid[1], error and read_data stable for all 5 cycles. ch0 (valid throughout) is accepted only after the response handshake.
- Reset mid-response: assert clear_n=0 while in RESPOND → next cycle all valid/ready outputs are 0 and the pointer restarts so ch0 is granted first. The earlier write is readable afterwards.
- Strobe build: write 0xFFFFFFFF, then write 0x00000000 with strobe 4'b0101, then read → 0xFF00FF00.
